// File: rtl/ram8.sv
// ram8: eight-entry WIDTH-bit register bank with combinational read through mux8way16
// and an 8-cycle scrub to CLEAR_VALUE. Optional macro RAM8_BYPASS_EN adds write-through forwarding.
module mux8way16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] e_i,
  input  logic [WIDTH-1:0] f_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] h_i,
  input  logic [2:0]       sel_i,
  output logic [WIDTH-1:0] out_o
);

  always_comb begin
    out_o = a_i;
    case (sel_i)
      3'd0: out_o = a_i;
      3'd1: out_o = b_i;
      3'd2: out_o = c_i;
      3'd3: out_o = d_i;
      3'd4: out_o = e_i;
      3'd5: out_o = f_i;
      3'd6: out_o = g_i;
      3'd7: out_o = h_i;
    endcase
  end

endmodule

module ram8 #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int unsigned DEPTH = 8;

  typedef enum logic {
    S_IDLE,
    S_SCRUB
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sc_q, sc_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= CLEAR_VALUE;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Loads are honoured only in IDLE; SCRUB owns the write port and ignores load/clear.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: begin
        if (load) mem_d[address] = in;
        if (clear) begin
          state_d = S_SCRUB;
          sc_d    = '0;
        end
      end
      S_SCRUB: begin
        mem_d[sc_q] = CLEAR_VALUE;
        sc_d        = 3'(sc_q + 3'd1);
        if (sc_q == 3'd7) state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SCRUB);
  end

  assign busy = busy_q;

  mux8way16 #(.WIDTH(WIDTH)) u_rd_mux (
    .a_i   (mem_q[0]),
    .b_i   (mem_q[1]),
    .c_i   (mem_q[2]),
    .d_i   (mem_q[3]),
    .e_i   (mem_q[4]),
    .f_i   (mem_q[5]),
    .g_i   (mem_q[6]),
    .h_i   (mem_q[7]),
    .sel_i (address),
    .out_o (rd_data)
  );

`ifdef RAM8_BYPASS_EN
  // Forward write data in the cycle a load is accepted.
  assign out = (load && !busy_q) ? in : rd_data;
`else
  assign out = rd_data;
`endif

endmodule
